// File: rtl/sctrl_pkg.sv
// Shared types and constants for the sensor capture controller.
package sctrl_pkg;

    localparam int SCTRL_DEPTH = 64;
    localparam int SCTRL_AW    = 6;
    localparam int SCTRL_DW    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        FULL = 2'd2
    } sctrl_state_e;

endpackage

// File: rtl/sctrl_buf.sv
// Flop-based sample buffer: one write port and one registered read port.
// A write and a read of the same index in one cycle return the old contents.
module sctrl_buf
    import sctrl_pkg::*;
#(
    parameter int DW    = SCTRL_DW,
    parameter int AW    = SCTRL_AW,
    parameter int DEPTH = SCTRL_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0]    mem_reg [DEPTH];
    logic [DW-1:0]    rd_data_reg;
    logic [DEPTH-1:0] wr_sel;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    // Reads sample the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sensor_ctrl.sv
// Sensor capture controller: fills a 64-entry buffer and flags when full.
// Optional build macro SCTRL_DROP_CNT_EN adds a saturating count of samples offered while full.
module sensor_ctrl
    import sctrl_pkg::*;
#(
    parameter int DATA_W = SCTRL_DW,
    parameter int DEPTH  = SCTRL_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sctrl_en,
    input  logic                sctrl_clear,
    input  logic [SCTRL_AW-1:0] sctrl_addr,
    output logic [DATA_W-1:0]   sctrl_out,
    output logic                sctrl_interrupt,
    output logic                sensor_en,
    input  logic                sensor_ready,
    input  logic [DATA_W-1:0]   sensor_out
`ifdef SCTRL_DROP_CNT_EN
    ,
    output logic [15:0]         sctrl_drop_cnt
`endif
);

    sctrl_state_e        state_reg, state_next;
    logic [SCTRL_AW:0]   cnt_reg, cnt_next;
    logic                handshake;
    logic                wr_en;

    assign handshake = (state_reg == CAPT) && sensor_ready;
    // Clear wins over a coincident handshake; that sample is dropped.
    assign wr_en     = handshake && !sctrl_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (sctrl_clear) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            if (handshake) begin
                cnt_next = cnt_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (sctrl_en && (cnt_reg < (SCTRL_AW + 1)'(DEPTH))) begin
                        state_next = CAPT;
                    end
                end
                CAPT: begin
                    if (handshake && (cnt_reg == (SCTRL_AW + 1)'(DEPTH - 1))) begin
                        state_next = FULL;
                    end else if (!sctrl_en) begin
                        state_next = IDLE;
                    end
                end
                FULL:    state_next = FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    assign sensor_en       = (state_reg == CAPT);
    assign sctrl_interrupt = (state_reg == FULL);

    sctrl_buf #(
        .DW    (DATA_W),
        .AW    (SCTRL_AW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (cnt_reg[SCTRL_AW-1:0]),
        .wr_data (sensor_out),
        .rd_addr (sctrl_addr),
        .rd_data (sctrl_out)
    );

`ifdef SCTRL_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || sctrl_clear) begin
            drop_cnt_reg <= '0;
        end else if ((state_reg == FULL) && sensor_ready && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign sctrl_drop_cnt = drop_cnt_reg;
`endif

endmodule
